mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data/instruction memory between three requesters: instruction fetch,
//  load unit and store unit. One transaction is in flight at a time.
//  Memory request inputs are edge-triggered, so this block turns level req/ack handshakes
//  into single-cycle request pulses.
//  It waits a fixed memory latency, captures read data and returns a one-cycle ack.
//  Sits between the CPU pipeline front-end/LSU and the memory model.
// PARAMETERS
//  MEM_LAT      2  cycles from request pulse to valid memory read data (>=1)
//  STARVE_LIMIT 4  consecutive lost arbitrations before fetch is forced to win (>=1)
// PORTS
//  clock          in   1   single clock, all state on posedge
//  reset          in   1   asynchronous, active-high; clears all state
//  if_req         in   1   fetch request; held with if_addr until if_ack
//  if_addr        in   32  fetch byte address
//  if_ack         out  1   one-cycle pulse; if_data valid this cycle and held after
//  if_data        out  32  fetched instruction
//  ld_req         in   1   load request; held with ld_addr until ld_ack
//  ld_addr        in   32  load byte address
//  ld_ack         out  1   one-cycle pulse; ld_data valid
//  ld_data        out  32  loaded word
//  st_req         in   1   store request; held with st_addr/st_data/st_type until st_ack
//  st_addr        in   32  store byte address
//  st_data        in   32  store data
//  st_type        in   3   000=SB 001=SH 010=SW
//  st_ack         out  1   one-cycle pulse; store retired
//  st_err         out  1   pulses with st_ack when st_type is illegal
//  mem_inst_req   out  1   pulse to memory instruction read port
//  mem_inst_addr  out  32  instruction read address
//  mem_inst_rdata in   32  instruction read data
//  mem_ld_req     out  1   pulse to memory load port
//  mem_ld_addr    out  32  load address
//  mem_ld_rdata   in   32  load read data
//  mem_wr_req     out  1   pulse to memory write port
//  mem_wr_addr    out  32  write address
//  mem_wr_data    out  32  write data
//  mem_wr_type    out  3   write type
//  busy           out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, starve counter 0.
//  Reset mid-transaction: abort, no ack. A store already pulsed may have been written.
//  States:
//   IDLE  -> ISSUE when any req is high.
//            Grant is latched with its operands into the mem_*_addr/data/type regs.
//   ISSUE -> granted mem_*_req=1 for exactly one cycle, then WAIT with count=MEM_LAT-1.
//            An illegal store type goes to DONE without pulsing.
//   WAIT  -> stays until count reaches 0 (MEM_LAT cycles after ISSUE),
//            then DONE. All mem_*_req stay 0.
//   DONE  -> captures mem_*_rdata into if_data/ld_data; pulses the granted ack; back to IDLE.
//  Latency: req sampled high at IDLE edge N -> ack high in cycle N+2+MEM_LAT.
//   With MEM_LAT=2 that is 4 cycles; the next grant is possible at N+3+MEM_LAT.
//  Priority: st > ld > if.
//   Starve counter increments (saturating) when if_req is high at a grant and fetch loses;
//   it clears when fetch wins.
//   When the counter equals STARVE_LIMIT, fetch wins over ld and st.
//  Handshake:
//   - Requester drops req in the cycle after ack.
//   - req still high in IDLE after DONE is a new request.
//   - Operands are sampled only at grant; later changes are ignored.
//  Simultaneous requests: one grant; the losers stay pending with no ack.
//  mem_*_addr/data/type hold their last value while idle. Addresses pass unmodified (no alignment check).
//  if_data/ld_data hold until the next ack for the same requester.
// TESTING
//  1 Reset then lone if_req, if_addr=0x0 (MEM_LAT=2) ->
//    mem_inst_req pulses 1 cycle; if_ack at cycle 4; if_data=mem word 0.
//  2 st_req SW addr=0x1000 data=0xDEADBEEF, then ld_req addr=0x1000 ->
//    mem_wr_req pulse, st_ack; then ld_ack with ld_data=0xDEADBEEF.
//  3 if_req, ld_req and st_req all raised in the same cycle ->
//    order st_ack, ld_ack, if_ack; each ack is 1 cycle; no overlapping mem pulses.
//  4 ld_req and st_req held continuously with if_req high ->
//    fetch granted on the 5th arbitration (STARVE_LIMIT=4); counter back to 0.
//  5 st_type=3'b111 -> no mem_wr_req; st_ack and st_err both pulse 1 cycle.
//  6 reset asserted during WAIT of a load ->
//    outputs 0 immediately; no ld_ack; a new ld_req after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if;
   // fetch requester
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_data;
   // load requester
   logic        ld_req;
   logic [31:0] ld_addr;
   logic        ld_ack;
   logic [31:0] ld_data;
   // store requester
   logic        st_req;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_type;
   logic        st_ack;
   logic        st_err;
   // memory ports
   logic        mem_inst_req;
   logic [31:0] mem_inst_addr;
   logic [31:0] mem_inst_rdata;
   logic        mem_ld_req;
   logic [31:0] mem_ld_addr;
   logic [31:0] mem_ld_rdata;
   logic        mem_wr_req;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic [2:0]  mem_wr_type;
   logic        busy;

   // arbiter view
   modport slave (
      input  if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_data, st_type,
             mem_inst_rdata, mem_ld_rdata,
      output if_ack, if_data, ld_ack, ld_data, st_ack, st_err,
             mem_inst_req, mem_inst_addr, mem_ld_req, mem_ld_addr,
             mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_type, busy
   );

   // requesters plus memory view
   modport master (
      output if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_data, st_type,
             mem_inst_rdata, mem_ld_rdata,
      input  if_ack, if_data, ld_ack, ld_data, st_ack, st_err,
             mem_inst_req, mem_inst_addr, mem_ld_req, mem_ld_addr,
             mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_type, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load/store arbiter onto a single fixed-latency memory
module mem_port_arbiter #(
   parameter int MEM_LAT      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(MEM_LAT + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {G_NONE, G_IF, G_LD, G_ST} grant_t;

   state_t         state;
   state_t         state_nxt;
   grant_t         grant;
   grant_t         grant_sel;
   logic [CW-1:0]  count;
   logic [SW-1:0]  starve;
   logic           st_illegal;
   logic           any_req;
   logic           starved;
   logic           st_legal;

   assign any_req  = bus.if_req | bus.ld_req | bus.st_req;
   assign starved  = (starve == SW'(STARVE_LIMIT));
   assign st_legal = (bus.st_type <= 3'b010);
   assign bus.busy = (state != IDLE);

   // pick the winner: a starved fetch beats everything, otherwise store > load > fetch
   always_comb begin
      grant_sel = G_NONE;
      if (bus.if_req && starved)
         grant_sel = G_IF;
      else if (bus.st_req)
         grant_sel = G_ST;
      else if (bus.ld_req)
         grant_sel = G_LD;
      else if (bus.if_req)
         grant_sel = G_IF;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic; an illegal store skips the memory and the latency wait
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (any_req) state_nxt = ISSUE;
         ISSUE: state_nxt = (grant == G_ST && st_illegal) ? DONE : WAIT;
         WAIT:  if (count == '0) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // grant/operand capture, memory pulses, latency count, read-data capture and acks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant             <= G_NONE;
         count             <= '0;
         starve            <= '0;
         st_illegal        <= 1'b0;
         bus.if_ack        <= 1'b0;
         bus.if_data       <= '0;
         bus.ld_ack        <= 1'b0;
         bus.ld_data       <= '0;
         bus.st_ack        <= 1'b0;
         bus.st_err        <= 1'b0;
         bus.mem_inst_req  <= 1'b0;
         bus.mem_inst_addr <= '0;
         bus.mem_ld_req    <= 1'b0;
         bus.mem_ld_addr   <= '0;
         bus.mem_wr_req    <= 1'b0;
         bus.mem_wr_addr   <= '0;
         bus.mem_wr_data   <= '0;
         bus.mem_wr_type   <= '0;
      end else begin
         // pulses and acks last exactly one cycle
         bus.mem_inst_req <= 1'b0;
         bus.mem_ld_req   <= 1'b0;
         bus.mem_wr_req   <= 1'b0;
         bus.if_ack       <= 1'b0;
         bus.ld_ack       <= 1'b0;
         bus.st_ack       <= 1'b0;
         bus.st_err       <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant <= grant_sel;
                  case (grant_sel)
                     G_IF: begin
                        bus.mem_inst_addr <= bus.if_addr;
                        bus.mem_inst_req  <= 1'b1;
                     end
                     G_LD: begin
                        bus.mem_ld_addr <= bus.ld_addr;
                        bus.mem_ld_req  <= 1'b1;
                     end
                     G_ST: begin
                        bus.mem_wr_addr <= bus.st_addr;
                        bus.mem_wr_data <= bus.st_data;
                        bus.mem_wr_type <= bus.st_type;
                        bus.mem_wr_req  <= st_legal;
                        st_illegal      <= !st_legal;
                     end
                     default: ;
                  endcase
                  if (grant_sel == G_IF)
                     starve <= '0;
                  else if (bus.if_req && !starved)
                     starve <= starve + SW'(1);
               end
            end
            ISSUE: begin
               count <= CW'(MEM_LAT - 1);
               if (grant == G_ST && st_illegal) begin
                  bus.st_ack <= 1'b1;
                  bus.st_err <= 1'b1;
               end
            end
            WAIT: begin
               if (count == '0) begin
                  case (grant)
                     G_IF: begin
                        bus.if_data <= bus.mem_inst_rdata;
                        bus.if_ack  <= 1'b1;
                     end
                     G_LD: begin
                        bus.ld_data <= bus.mem_ld_rdata;
                        bus.ld_ack  <= 1'b1;
                     end
                     G_ST: bus.st_ack <= 1'b1;
                     default: ;
                  endcase
               end else begin
                  count <= count - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int MEM_LAT = 2;
   localparam int STARVE  = 4;
   localparam logic [1:0] K_IF = 2'd0;
   localparam logic [1:0] K_LD = 2'd1;
   localparam logic [1:0] K_ST = 2'd2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // memory model: reads register the addressed word on the request pulse
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (bus.mem_inst_req) bus.mem_inst_rdata <= mem[bus.mem_inst_addr[13:2]];
      if (bus.mem_ld_req)   bus.mem_ld_rdata   <= mem[bus.mem_ld_addr[13:2]];
      if (bus.mem_wr_req) begin
         case (bus.mem_wr_type)
            3'b000:  mem[bus.mem_wr_addr[13:2]][8*int'(bus.mem_wr_addr[1:0]) +: 8] <= bus.mem_wr_data[7:0];
            3'b001:  mem[bus.mem_wr_addr[13:2]][16*int'(bus.mem_wr_addr[1]) +: 16] <= bus.mem_wr_data[15:0];
            default: mem[bus.mem_wr_addr[13:2]] <= bus.mem_wr_data;
         endcase
      end
   end

   // pulse/ack monitor
   int n_inst = 0, n_ld = 0, n_wr = 0, n_ldack = 0;
   int overlap_mem = 0, overlap_ack = 0, long_pulse = 0, long_ack = 0;
   logic p_i = 0, p_l = 0, p_w = 0, p_ia = 0, p_la = 0, p_sa = 0;
   always @(negedge clk) begin
      if (rst) begin
         p_i = 0; p_l = 0; p_w = 0; p_ia = 0; p_la = 0; p_sa = 0;
      end else begin
         if (bus.mem_inst_req) n_inst++;
         if (bus.mem_ld_req)   n_ld++;
         if (bus.mem_wr_req)   n_wr++;
         if (bus.ld_ack)       n_ldack++;
         if (int'(bus.mem_inst_req) + int'(bus.mem_ld_req) + int'(bus.mem_wr_req) > 1) overlap_mem++;
         if (int'(bus.if_ack) + int'(bus.ld_ack) + int'(bus.st_ack) > 1) overlap_ack++;
         if ((bus.mem_inst_req && p_i) || (bus.mem_ld_req && p_l) || (bus.mem_wr_req && p_w)) long_pulse++;
         if ((bus.if_ack && p_ia) || (bus.ld_ack && p_la) || (bus.st_ack && p_sa)) long_ack++;
         p_i = bus.mem_inst_req; p_l = bus.mem_ld_req; p_w = bus.mem_wr_req;
         p_ia = bus.if_ack; p_la = bus.ld_ack; p_sa = bus.st_ack;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  stype;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[11];

   // one transaction from a lone requester; operands are scrambled after the grant
   task automatic do_vec(input vec_t v, input int idx);
      int lat;
      bit got;
      logic [31:0] data;
      logic err;
      int pi, pl, pw;
      logic [31:0] exp_pulses;
      logic [31:0] port_addr;
      data = '0;
      err  = 1'b0;
      @(negedge clk);
      pi = n_inst; pl = n_ld; pw = n_wr;
      case (v.kind)
         K_IF: begin bus.if_addr = v.addr; bus.if_req = 1'b1; end
         K_LD: begin bus.ld_addr = v.addr; bus.ld_req = 1'b1; end
         default: begin
            bus.st_addr = v.addr; bus.st_data = v.wdata; bus.st_type = v.stype; bus.st_req = 1'b1;
         end
      endcase
      lat = 0;
      got = 0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bus.if_addr = ~v.addr; bus.ld_addr = ~v.addr; bus.st_addr = ~v.addr;
            bus.st_data = ~v.wdata; bus.st_type = v.stype ^ 3'b101;
         end
         if (v.kind == K_IF && bus.if_ack) begin got = 1; data = bus.if_data; bus.if_req = 1'b0; end
         if (v.kind == K_LD && bus.ld_ack) begin got = 1; data = bus.ld_data; bus.ld_req = 1'b0; end
         if (v.kind == K_ST && bus.st_ack) begin got = 1; err = bus.st_err; bus.st_req = 1'b0; end
      end
      chk($sformatf("v%0d_latency", idx), got ? lat : -1, v.exp_lat);
      if (v.kind == K_ST) chk($sformatf("v%0d_st_err", idx), {31'd0, err}, {31'd0, v.exp_err});
      else                chk($sformatf("v%0d_rdata", idx), data, v.exp_data);
      @(negedge clk);
      chk($sformatf("v%0d_ack_one_cycle", idx), {28'd0, bus.if_ack, bus.ld_ack, bus.st_ack, bus.st_err}, 32'd0);
      exp_pulses = {8'd0, (v.kind == K_IF) ? 8'd1 : 8'd0, (v.kind == K_LD) ? 8'd1 : 8'd0,
                    (v.kind == K_ST && !v.exp_err) ? 8'd1 : 8'd0};
      chk($sformatf("v%0d_mem_pulses", idx),
          {8'd0, 8'(n_inst - pi), 8'(n_ld - pl), 8'(n_wr - pw)}, exp_pulses);
      case (v.kind)
         K_IF:    port_addr = bus.mem_inst_addr;
         K_LD:    port_addr = bus.mem_ld_addr;
         default: port_addr = bus.mem_wr_addr;
      endcase
      chk($sformatf("v%0d_mem_addr", idx), port_addr, v.addr);
   endtask

   logic [1:0] order[$];

   // collect n acks in arrival order, optionally dropping each req on its ack
   task automatic run_acks(input int n, input bit drop, output logic [31:0] packed_order);
      int cyc;
      cyc = 0;
      packed_order = '0;
      order.delete();
      while (order.size() < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (bus.st_ack) begin order.push_back(K_ST); if (drop) bus.st_req = 1'b0; end
         if (bus.ld_ack) begin order.push_back(K_LD); if (drop) bus.ld_req = 1'b0; end
         if (bus.if_ack) begin order.push_back(K_IF); if (drop) bus.if_req = 1'b0; end
      end
      foreach (order[i]) packed_order = {packed_order[29:0], order[i]};
   endtask

   logic [31:0] got_order;
   int          ack_snap;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[0] = 32'h0000_0013;
      bus.mem_inst_rdata = '0;
      bus.mem_ld_rdata   = '0;
      bus.if_req = 0; bus.if_addr = '0;
      bus.ld_req = 0; bus.ld_addr = '0;
      bus.st_req = 0; bus.st_addr = '0; bus.st_data = '0; bus.st_type = '0;

      vecs[0]  = '{K_IF, 32'h0000_0000, 32'h0,         3'b000, 32'h0000_0013, 1'b0, 4};
      vecs[1]  = '{K_ST, 32'h0000_1000, 32'hDEAD_BEEF, 3'b010, 32'h0,         1'b0, 4};
      vecs[2]  = '{K_LD, 32'h0000_1000, 32'h0,         3'b000, 32'hDEAD_BEEF, 1'b0, 4};
      vecs[3]  = '{K_ST, 32'h0000_1001, 32'h0000_00A5, 3'b000, 32'h0,         1'b0, 4};
      vecs[4]  = '{K_LD, 32'h0000_1000, 32'h0,         3'b000, 32'hDEAD_A5EF, 1'b0, 4};
      vecs[5]  = '{K_ST, 32'h0000_1002, 32'h0000_1234, 3'b001, 32'h0,         1'b0, 4};
      vecs[6]  = '{K_LD, 32'h0000_1000, 32'h0,         3'b000, 32'h1234_A5EF, 1'b0, 4};
      vecs[7]  = '{K_ST, 32'h0000_1000, 32'h0BAD_0BAD, 3'b111, 32'h0,         1'b1, 2};
      vecs[8]  = '{K_LD, 32'h0000_1000, 32'h0,         3'b000, 32'h1234_A5EF, 1'b0, 4};
      vecs[9]  = '{K_IF, 32'h0000_1000, 32'h0,         3'b000, 32'h1234_A5EF, 1'b0, 4};
      vecs[10] = '{K_LD, 32'h0000_2000, 32'h0,         3'b000, 32'h1122_3344, 1'b0, 4};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_acks", {28'd0, bus.if_ack, bus.ld_ack, bus.st_ack, bus.st_err}, 32'd0);
      chk("rst_mem_reqs", {29'd0, bus.mem_inst_req, bus.mem_ld_req, bus.mem_wr_req}, 32'd0);
      chk("rst_if_data", bus.if_data, 32'd0);
      chk("rst_ld_data", bus.ld_data, 32'd0);
      chk("rst_mem_wr_addr", bus.mem_wr_addr, 32'd0);
      rst = 1'b0;

      // lone-requester vectors
      for (int i = 0; i < 10; i++) do_vec(vecs[i], i);

      // all three raised together: store, then load, then fetch
      @(negedge clk);
      bus.st_addr = 32'h0000_2000; bus.st_data = 32'h1122_3344; bus.st_type = 3'b010;
      bus.ld_addr = 32'h0000_2000;
      bus.if_addr = 32'h0000_0000;
      bus.st_req = 1'b1; bus.ld_req = 1'b1; bus.if_req = 1'b1;
      run_acks(3, 1'b1, got_order);
      chk("simul_ack_count", order.size(), 3);
      chk("simul_order", got_order, {26'd0, K_ST, K_LD, K_IF});
      chk("simul_ld_data", bus.ld_data, 32'h1122_3344);
      chk("simul_if_data", bus.if_data, 32'h0000_0013);

      // fetch starvation: st wins four times, then fetch, then st again
      @(negedge clk);
      bus.st_addr = 32'h0000_3000; bus.st_data = 32'h5555_AAAA; bus.st_type = 3'b010;
      bus.ld_addr = 32'h0000_1000;
      bus.if_addr = 32'h0000_0000;
      bus.st_req = 1'b1; bus.ld_req = 1'b1; bus.if_req = 1'b1;
      run_acks(6, 1'b0, got_order);
      bus.st_req = 1'b0; bus.ld_req = 1'b0; bus.if_req = 1'b0;
      chk("starve_ack_count", order.size(), 6);
      chk("starve_order", got_order, {20'd0, K_ST, K_ST, K_ST, K_ST, K_IF, K_ST});
      repeat (3) @(negedge clk);
      chk("starve_idle_busy", {31'd0, bus.busy}, 32'd0);

      // reset in the WAIT state of a load
      @(negedge clk);
      bus.ld_addr = 32'h0000_2000; bus.ld_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      ack_snap = n_ldack;
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_ld_ack", {30'd0, bus.ld_ack, bus.mem_ld_req}, 32'd0);
      chk("midrst_ld_data", bus.ld_data, 32'd0);
      chk("midrst_mem_ld_addr", bus.mem_ld_addr, 32'd0);
      bus.ld_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_ack", n_ldack, ack_snap);
      do_vec(vecs[10], 10);

      chk("mem_pulse_overlap", overlap_mem, 0);
      chk("ack_overlap", overlap_ack, 0);
      chk("mem_pulse_width", long_pulse, 0);
      chk("ack_width", long_ack, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
